// File: rtl/iopmp_entry_scanner.sv
// rtl/iopmp_entry_scanner.sv - sequential IOPMP entry table read-out engine
// Fetches a contiguous index range from the entry RAM and streams it with backpressure.
module iopmp_entry_scanner #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] first_i,
    input  logic [ADDR_WIDTH-1:0] last_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  entry_valid_o,
    input  logic                  entry_ready_i,
    output logic [DATA_WIDTH-1:0] entry_data_o,
    output logic [ADDR_WIDTH-1:0] entry_idx_o,
    output logic                  entry_last_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_MAX_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_last;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_infl_idx;
    logic                  r_infl_last;
    logic                  r_empty_done;

    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [ADDR_WIDTH-1:0] r_buf_idx  [2];
    logic                  r_buf_last [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_first_oob;
    logic [ADDR_WIDTH-1:0] w_last_clamped;
    logic                  w_empty;
    logic [1:0]            w_load;
    logic                  w_hs;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_head_last;
    logic                  w_at_last;

    // Range checks only exist when the index space is wider than the table.
    generate
        if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial
            assign w_first_oob    = (first_i > LP_MAX_IDX);
            assign w_last_clamped = (last_i > LP_MAX_IDX) ? LP_MAX_IDX : last_i;
        end else begin : g_full
            assign w_first_oob    = 1'b0;
            assign w_last_clamped = last_i;
        end
    endgenerate

    assign w_empty     = w_first_oob || (first_i > w_last_clamped);
    assign w_load      = r_count + {1'b0, r_inflight};
    assign w_hs        = entry_valid_o && entry_ready_i;
    assign w_at_last   = (r_addr == r_last);
    assign w_head_last = r_buf_last[r_rd_ptr];
    assign w_push      = r_inflight && !abort_i;
    // A full pipeline may still issue when a slot frees in the same cycle.
    assign w_issue     = (r_state == S_SCAN) && !abort_i &&
                         ((w_load < 2'd2) || ((w_load == 2'd2) && w_hs));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && !w_empty) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort_i) begin
                    w_next = S_IDLE;
                end else if (w_issue && w_at_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i || (w_hs && w_head_last)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (r_state != S_IDLE);
        ram_en_o = w_issue;
        done_o   = r_empty_done ||
                   ((r_state == S_DRAIN) && !abort_i && w_hs && w_head_last);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr       <= '0;
            r_last       <= '0;
            r_inflight   <= 1'b0;
            r_infl_idx   <= '0;
            r_infl_last  <= 1'b0;
            r_empty_done <= 1'b0;
        end else begin
            r_empty_done <= (r_state == S_IDLE) && start_i && w_empty;
            if (r_state == S_IDLE && start_i) begin
                r_addr <= first_i;
                r_last <= w_last_clamped;
            end else if (w_issue && !w_at_last) begin
                r_addr <= r_addr + 1'b1;
            end
            r_inflight  <= w_issue;
            r_infl_idx  <= r_addr;
            r_infl_last <= w_at_last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= ram_rdata_i;
                r_buf_idx[r_wr_ptr]  <= r_infl_idx;
                r_buf_last[r_wr_ptr] <= r_infl_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_hs) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_hs};
        end
    end

    // Head fields are masked so idle outputs read as zero regardless of stale slots.
    assign entry_valid_o = (r_count != 2'd0);
    assign entry_data_o  = entry_valid_o ? r_buf_data[r_rd_ptr] : '0;
    assign entry_idx_o   = entry_valid_o ? r_buf_idx[r_rd_ptr] : '0;
    assign entry_last_o  = entry_valid_o && w_head_last;
    assign ram_addr_o    = r_addr;

endmodule

// File: tb/tb_iopmp_entry_scanner.sv
// tb/tb_iopmp_entry_scanner.sv - self-checking bench for iopmp_entry_scanner
// Randomized ranges and backpressure scored against an index-range reference model.
module tb_iopmp_entry_scanner;

    localparam int DW    = 128;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] first_i;
    logic [AW-1:0] last_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_rdata;
    logic          entry_valid_o;
    logic          entry_ready_i;
    logic [DW-1:0] entry_data_o;
    logic [AW-1:0] entry_idx_o;
    logic          entry_last_o;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    iopmp_entry_scanner #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .first_i      (first_i),
        .last_i       (last_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ram_en_o     (ram_en_o),
        .ram_addr_o   (ram_addr_o),
        .ram_rdata_i  (ram_rdata),
        .entry_valid_o(entry_valid_o),
        .entry_ready_i(entry_ready_i),
        .entry_data_o (entry_data_o),
        .entry_idx_o  (entry_idx_o),
        .entry_last_o (entry_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en_o) ram_rdata <= mem[ram_addr_o];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = pattern ? DW'(i * 32'h11) : {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // rmode: 0 ready always, 1 random ready and stray starts, 2 ready one cycle in three
    task automatic run_scan(input int first, input int last, input int rmode,
                            input int abort_at, input int rst_at);
        int eff_last, n, nreads, nacc, done_cycle, first_hs;
        bit empty, finished, ended, hs, exp_done, exp_busy, prev_v, prev_r;
        logic [DW-1:0] prev_d;
        logic [AW-1:0] prev_i;
        eff_last = (last > DEPTH - 1) ? DEPTH - 1 : last;
        empty    = (first >= DEPTH) || (first > eff_last);
        n        = empty ? 0 : eff_last - first + 1;
        nreads = 0; nacc = 0; done_cycle = -1; first_hs = -1;
        finished = 0; ended = 0; prev_v = 0; prev_r = 0; prev_d = '0; prev_i = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start_i = (c == 0) || (rmode == 1 && !empty && !finished &&
                      (abort_at < 0 || c < abort_at) && (rst_at < 0 || c < rst_at) &&
                      $urandom_range(0, 3) == 0);
            first_i = (c == 0) ? AW'(first) : AW'($urandom);
            last_i  = (c == 0) ? AW'(last) : AW'($urandom);
            abort_i = (c == abort_at);
            rst_i   = (c == rst_at);
            entry_ready_i = (rmode == 0) ? 1'b1 :
                            (rmode == 2) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (c == 0) begin
                chk("idle_before_start", busy_o, 1'b0);
                continue;
            end
            if (finished) begin
                chk("end_busy", busy_o, 1'b0);
                chk("end_valid", entry_valid_o, 1'b0);
                chk("end_ram_en", ram_en_o, 1'b0);
                ended = 1;
                break;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk("rst_busy", busy_o, 1'b0);
                chk("rst_done", done_o, 1'b0);
                chk("rst_ram_en", ram_en_o, 1'b0);
                chk("rst_addr", ram_addr_o, 0);
                chk("rst_valid", entry_valid_o, 1'b0);
                chk("rst_data", entry_data_o, 0);
                chk("rst_idx", entry_idx_o, 0);
                chk("rst_last", entry_last_o, 1'b0);
                ended = 1;
                break;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                chk("abort_busy", busy_o, 1'b0);
                chk("abort_valid", entry_valid_o, 1'b0);
                chk("abort_ram_en", ram_en_o, 1'b0);
                chk("abort_done", done_o, 1'b0);
                ended = 1;
                break;
            end
            if (c == rst_at) continue;
            if (c == abort_at) begin
                chk("abort_cycle_done", done_o, 1'b0);
                continue;
            end
            hs = entry_valid_o && entry_ready_i;
            if (ram_en_o) begin
                chk("rd_addr", ram_addr_o, first + nreads);
                nreads++;
                chk("rd_bound", nreads <= n, 1'b1);
            end
            if (hs) begin
                chk("out_idx", entry_idx_o, first + nacc);
                chk("out_data", entry_data_o, mem[(first + nacc) % DEPTH]);
                chk("out_last", entry_last_o, (first + nacc) == eff_last);
                nacc++;
                if (first_hs < 0) first_hs = c;
            end
            chk("outstanding_le2", (nreads - nacc) <= 2, 1'b1);
            if (prev_v && !prev_r) begin
                chk("stall_valid", entry_valid_o, 1'b1);
                chk("stall_data", entry_data_o, prev_d);
                chk("stall_idx", entry_idx_o, prev_i);
            end
            exp_done = empty ? (c == 1) : (hs && nacc == n);
            exp_busy = !empty;
            chk("done", done_o, exp_done);
            chk("busy", busy_o, exp_busy);
            prev_v = entry_valid_o; prev_r = entry_ready_i;
            prev_d = entry_data_o;  prev_i = entry_idx_o;
            if (exp_done) begin
                finished   = 1;
                done_cycle = c;
            end
        end
        chk("scan_terminated", ended, 1'b1);
        if (rmode == 0 && abort_at < 0 && rst_at < 0) begin
            chk("done_cycle", done_cycle, empty ? 1 : n + 2);
            chk("entry_count", nacc, n);
            if (!empty) chk("first_entry_cycle", first_hs, 3);
        end
        @(negedge clk);
        start_i = 0; abort_i = 0; rst_i = 0; entry_ready_i = 1;
    endtask

    initial begin
        rst_i = 1; start_i = 0; first_i = '0; last_i = '0; abort_i = 0;
        entry_ready_i = 0; ram_rdata = '0;
        fill_mem(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_ram_en", ram_en_o, 1'b0);
        chk("reset_addr", ram_addr_o, 0);
        chk("reset_valid", entry_valid_o, 1'b0);
        chk("reset_data", entry_data_o, 0);
        chk("reset_idx", entry_idx_o, 0);
        chk("reset_last", entry_last_o, 1'b0);
        rst_i = 0;

        run_scan(0, 31, 0, -1, -1);
        run_scan(5, 5, 0, -1, -1);
        run_scan(9, 4, 0, -1, -1);
        run_scan(0, 7, 2, -1, -1);
        run_scan(0, 31, 0, 5, -1);
        run_scan(3, 6, 0, -1, -1);
        run_scan(0, 31, 0, -1, 4);
        run_scan(10, 12, 0, -1, -1);

        @(negedge clk);
        abort_i = 1;
        #1;
        chk("idle_abort_busy", busy_o, 1'b0);
        chk("idle_abort_done", done_o, 1'b0);
        @(negedge clk);
        abort_i = 0;
        #1;
        chk("idle_abort_after", busy_o, 1'b0);
        run_scan(28, 31, 0, -1, -1);

        for (int t = 0; t < 24; t++) begin
            int f, l, m, a;
            fill_mem(1'b0);
            f = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, DEPTH - 1);
            m = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0 && f <= l) ? $urandom_range(2, 20) : -1;
            run_scan(f, l, m, a, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
